// File: rtl/bist_pkg.sv
// Shared BIST definitions: fault-free control values and the fault control bundle.
package bist_pkg;

  localparam logic FAULT_NONE_F1 = 1'b1;
  localparam logic FAULT_NONE_F2 = 1'b1;
  localparam logic FAULT_NONE_F3 = 1'b0;

  typedef struct packed {
    logic f1;
    logic f2;
    logic f3;
  } fault_ctrl_t;

endpackage

// File: rtl/cut_fa_core.sv
// Combinational 1-bit full adder gate netlist with stuck-at fault injection points.
module cut_fa_core
  import bist_pkg::*;
(
  input  logic        a,
  input  logic        b,
  input  logic        cin,
  input  fault_ctrl_t fault,
  output logic        sum_d,
  output logic        cout_d
);

  logic a1;
  logic p;
  logic sum1;
  logic r;
  logic r1;
  logic q;

  // f1/f2 are active-low gates on internal nets; f3 forces the sum high.
  assign a1     = a & fault.f1;
  assign p      = a1 ^ b;
  assign sum1   = p ^ cin;
  assign r      = a1 & b;
  assign r1     = r & fault.f2;
  assign q      = p & cin;
  assign sum_d  = sum1 | fault.f3;
  assign cout_d = r1 | q;

endmodule

// File: rtl/cut_1bit_full_adder.sv
// Registered 1-bit full adder CUT with fault injection.
// Define CUT_FAULT_DETECT_EN to add the fault_det output driven by a fault-free golden copy.
module cut_1bit_full_adder
  import bist_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic f1,
  input  logic f2,
  input  logic f3,
  output logic sum,
  output logic cout
`ifdef CUT_FAULT_DETECT_EN
  ,
  output logic fault_det
`endif
);

  fault_ctrl_t fault;
  logic        sum_d;
  logic        cout_d;
  logic        sum_q;
  logic        cout_q;

  assign fault = '{f1: f1, f2: f2, f3: f3};

  cut_fa_core u_core (
    .a      (a),
    .b      (b),
    .cin    (cin),
    .fault  (fault),
    .sum_d  (sum_d),
    .cout_d (cout_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef CUT_FAULT_DETECT_EN
  localparam fault_ctrl_t FAULT_NONE = '{f1: FAULT_NONE_F1, f2: FAULT_NONE_F2, f3: FAULT_NONE_F3};

  logic gold_sum;
  logic gold_cout;
  logic fault_det_d;
  logic fault_det_q;

  // Golden copy sees the same operands with every fault control held inactive.
  cut_fa_core u_golden (
    .a      (a),
    .b      (b),
    .cin    (cin),
    .fault  (FAULT_NONE),
    .sum_d  (gold_sum),
    .cout_d (gold_cout)
  );

  always_comb begin
    fault_det_d = (gold_sum != sum_d) || (gold_cout != cout_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_det_q <= 1'b0;
    end else begin
      fault_det_q <= fault_det_d;
    end
  end

  assign fault_det = fault_det_q;
`endif

endmodule

// File: tb/tb_cut_1bit_full_adder.sv
// Scoreboard bench for cut_1bit_full_adder: directed spec vectors, random vectors, reset behaviour.
module tb_cut_1bit_full_adder;

  logic clk;
  logic rst_n;
  logic a, b, cin;
  logic f1, f2, f3;
  logic sum, cout;
`ifdef CUT_FAULT_DETECT_EN
  logic fault_det;
`endif

  typedef struct packed {
    logic s;
    logic c;
    logic d;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   txn      = 0;

  cut_1bit_full_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .f1    (f1),
    .f2    (f2),
    .f3    (f3),
    .sum   (sum),
`ifdef CUT_FAULT_DETECT_EN
    .cout  (cout),
    .fault_det (fault_det)
`else
    .cout  (cout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: arithmetic sum of the effective operands, then fault overrides.
  function automatic exp_t model(input logic ia, input logic ib, input logic ic,
                                 input logic if1, input logic if2, input logic if3);
    exp_t e;
    int   ea;
    int   total;
    int   gold;
    ea    = (if1 == 1'b1) ? int'(ia) : 0;
    total = ea + int'(ib) + int'(ic);
    e.s   = (total % 2 == 1) || (if3 == 1'b1);
    // Losing the A&B term removes the carry exactly when both effective addends are 1.
    if (if2 == 1'b0 && ea == 1 && ib == 1'b1) e.c = 1'b0;
    else e.c = (total >= 2);
    gold  = int'(ia) + int'(ib) + int'(ic);
    e.d   = (e.s != (gold % 2 == 1)) || (e.c != (gold >= 2));
    return e;
  endfunction

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic drive(input logic [2:0] abc, input logic [2:0] f);
    @(negedge clk);
    {a, b, cin} = abc;
    {f1, f2, f3} = f;
    exp_q.push_back(model(abc[2], abc[1], abc[0], f[2], f[1], f[0]));
  endtask

  // Monitor: every capture edge with an outstanding expectation produces one comparison.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d: abc=%b%b%b f=%b%b%b -> sum=%b cout=%b (exp %b %b)",
                 txn, a, b, cin, f1, f2, f3, sum, cout, e.s, e.c);
        check1("sum", sum, e.s);
        check1("cout", cout, e.c);
`ifdef CUT_FAULT_DETECT_EN
        check1("fault_det", fault_det, e.d);
`endif
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {a, b, cin} = 3'b000;
    {f1, f2, f3} = 3'b110;
    #12;
    check1("reset_sum", sum, 1'b0);
    check1("reset_cout", cout, 1'b0);
`ifdef CUT_FAULT_DETECT_EN
    check1("reset_fault_det", fault_det, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Fault-free directed, then full sweep
    drive(3'b000, 3'b110);
    drive(3'b011, 3'b110);
    drive(3'b101, 3'b110);
    for (int i = 0; i < 8; i++) drive(3'(i), 3'b110);
    // Single and combined faults from the fault table
    drive(3'b100, 3'b010);
    drive(3'b111, 3'b010);
    drive(3'b110, 3'b101);
    drive(3'b111, 3'b101);
    drive(3'b000, 3'b111);
    drive(3'b111, 3'b111);
    drive(3'b101, 3'b110);
    // Random operands and fault controls
    for (int i = 0; i < 120; i++) drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    drain();

    // Asynchronous reset between edges
    drive(3'b111, 3'b110);
    drain();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check1("async_rst_sum", sum, 1'b0);
    check1("async_rst_cout", cout, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check1("held_rst_sum", sum, 1'b0);
      check1("held_rst_cout", cout, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check1("post_release_sum", sum, 1'b0);
    check1("post_release_cout", cout, 1'b0);
    exp_q.push_back(model(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    drain();

    drive(3'b101, 3'b110);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
